// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - single-port RAM bus between the BIST engine and the RAM under test
interface ram_bist_if;
   logic        ram_ena;
   logic        ram_wena;
   logic [4:0]  ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;

   modport master (
      output ram_ena,
      output ram_wena,
      output ram_addr,
      output ram_data_in,
      input  ram_data_out
   );

   modport slave (
      input  ram_ena,
      input  ram_wena,
      input  ram_addr,
      input  ram_data_in,
      output ram_data_out
   );
endinterface

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - two-pass pattern/inverse-pattern BIST for a 32x32 RAM with 1-cycle read latency
module ram_bist #(
   parameter logic [31:0] PATTERN = 32'hA5A5A5A5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   ram_bist_if.master   ram,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [5:0]   err_cnt,
   output logic [4:0]   err_addr
);

   typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [5:0]  cnt_m1;
   logic [4:0]  next_addr;
   logic [4:0]  cmp_addr;
   logic [31:0] exp_word;
   logic        mismatch;

   function automatic logic [31:0] e_word(input logic inv, input logic [4:0] a);
      logic [31:0] w;
      w = PATTERN ^ {27'b0, a};
      return inv ? ~w : w;
   endfunction

   // cnt indexes the cycle within the current phase; reads return one cycle later,
   // so read cycle k compares the word requested in cycle k-1.
   always_comb begin
      cnt_m1    = cnt - 6'd1;
      next_addr = cnt[4:0] + 5'd1;
      cmp_addr  = cnt_m1[4:0];
      exp_word  = e_word(state == RD1, cmp_addr);
      mismatch  = 1'b0;
      if ((state == RD0 || state == RD1) && cnt != 6'd0)
         mismatch = (ram.ram_data_out != exp_word);
   end

   // Bus outputs are loaded with the values for the cycle being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= 6'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_cnt         <= 6'd0;
         err_addr        <= 5'd0;
         ram.ram_ena     <= 1'b0;
         ram.ram_wena    <= 1'b0;
         ram.ram_addr    <= 5'd0;
         ram.ram_data_in <= 32'd0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  state           <= WR0;
                  cnt             <= 6'd0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
                  err_cnt         <= 6'd0;
                  err_addr        <= 5'd0;
                  ram.ram_ena     <= 1'b1;
                  ram.ram_wena    <= 1'b1;
                  ram.ram_addr    <= 5'd0;
                  ram.ram_data_in <= e_word(1'b0, 5'd0);
               end
            end
            WR0, WR1: begin
               if (cnt == 6'd31) begin
                  state           <= (state == WR0) ? RD0 : RD1;
                  cnt             <= 6'd0;
                  ram.ram_wena    <= 1'b0;
                  ram.ram_addr    <= 5'd0;
                  ram.ram_data_in <= 32'd0;
               end else begin
                  cnt             <= cnt + 6'd1;
                  ram.ram_addr    <= next_addr;
                  ram.ram_data_in <= e_word(state == WR1, next_addr);
               end
            end
            RD0, RD1: begin
               if (mismatch) begin
                  if (err_cnt != 6'd63)
                     err_cnt <= err_cnt + 6'd1;
                  if (err_cnt == 6'd0)
                     err_addr <= cmp_addr;
               end
               if (cnt == 6'd32) begin
                  cnt <= 6'd0;
                  if (state == RD0) begin
                     state           <= WR1;
                     ram.ram_ena     <= 1'b1;
                     ram.ram_wena    <= 1'b1;
                     ram.ram_addr    <= 5'd0;
                     ram.ram_data_in <= e_word(1'b1, 5'd0);
                  end else begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_cnt == 6'd0) && !mismatch;
                  end
               end else if (cnt == 6'd31) begin
                  cnt          <= cnt + 6'd1;
                  ram.ram_ena  <= 1'b0;
                  ram.ram_addr <= 5'd0;
               end else begin
                  cnt          <= cnt + 6'd1;
                  ram.ram_addr <= next_addr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 The module SHALL have parameter PATTERN, default 32'hA5A5A5A5, which is the base test word.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: asynchronous reset, active low.
REQ-005 Port start SHALL be an input, 1 bit wide: a 1-cycle request to begin a test run.
REQ-006 Port ram_ena SHALL be an output, 1 bit wide: RAM enable.
REQ-007 Port ram_wena SHALL be an output, 1 bit wide: RAM write enable (1 = write, 0 = read).
REQ-008 Port ram_addr SHALL be an output, 5 bits wide: RAM word address (32 words).
REQ-009 Port ram_data_in SHALL be an output, 32 bits wide: write data to the RAM.
REQ-010 Port ram_data_out SHALL be an input, 32 bits wide: read data from the RAM, valid 1 cycle after a read is issued.
REQ-011 Port busy SHALL be an output, 1 bit wide: a test run is in progress.
REQ-012 Port done SHALL be an output, 1 bit wide: the run has finished; held until the next start or reset.
REQ-013 Port pass SHALL be an output, 1 bit wide: the finished run saw no mismatches; meaningful only when done=1.
REQ-014 Port err_cnt SHALL be an output, 6 bits wide: mismatch count, saturating at 63.
REQ-015 Port err_addr SHALL be an output, 5 bits wide: address of the first mismatch.

Function
REQ-016 The FSM SHALL have states IDLE, WR0, RD0, WR1, RD1 and FIN.
REQ-017 From IDLE or FIN, start=1 SHALL move the FSM to WR0 on the next edge, clear done, pass, err_cnt and err_addr, and set busy=1.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 Let e0(a) = PATTERN ^ {27'b0, a} and e1(a) = ~e0(a).
REQ-020 WR0 SHALL last 32 cycles and write e0(k) to addr k for k = 0..31 (ram_ena=1, ram_wena=1, one address per cycle, ascending).
REQ-021 The FSM SHALL then enter RD0.
REQ-022 RD0 SHALL last 33 cycles.
- Cycles 0..31: issue a read of addr k (ram_ena=1, ram_wena=0).
- Cycles 1..32: compare ram_data_out with e0(k-1).
- Cycle 32 is the drain cycle: ram_ena=0.
REQ-023 WR1 and RD1 SHALL behave like WR0 and RD0 but use e1; RD1 SHALL be followed by FIN.
REQ-024 A run SHALL keep busy=1 for exactly 130 cycles (32+33+32+33).
REQ-025 On a mismatch, err_cnt SHALL increment, saturating at 63.
REQ-026 The first mismatch of a run SHALL load its address into err_addr; later mismatches SHALL leave err_addr unchanged.
REQ-027 On entry to FIN, busy SHALL go to 0, done SHALL go to 1, and pass SHALL be set to (err_cnt==0 including the final compare).
REQ-028 FIN SHALL hold its outputs until start or reset.
REQ-029 In IDLE and FIN, ram_ena and ram_wena SHALL be 0, and ram_addr and ram_data_in SHALL be 0.
REQ-030 All outputs SHALL be registered, with no combinational path from ram_data_out to any output.

Reset
REQ-031 While rst_n=0, all outputs SHALL be 0 immediately (asynchronously) and the FSM SHALL be in IDLE.
REQ-032 rst_n=0 mid-run SHALL abort the run at once: ram_ena=0, busy=0, done=0.
REQ-033 After reset is released, no RAM access SHALL occur until start.
REQ-034 The first start after reset release SHALL perform a full 130-cycle run.

Verification
REQ-035 Reset: assert rst_n=0 with no clock running -> all outputs are 0.
REQ-036 Good RAM (32x32 model with 1-cycle read):
- Stimulus: pulse start.
- Write cycle for addr 5 carries 32'hA5A5A5A0.
- busy=1 for 130 cycles, then done=1, pass=1, err_cnt=0.
REQ-037 Stuck-at-0 on data bit 0 (bench forces ram_data_out[0]=0):
- 16 mismatches in RD0 (even addrs) and 16 in RD1 (odd addrs).
- Result: err_cnt=32, err_addr=0, pass=0.
REQ-038 All-ones data_out (forced to 32'hFFFFFFFF):
- 64 mismatches occur.
- Result: err_cnt=63 (saturated), err_addr=0, pass=0.
REQ-039 Start during busy: a second start pulse at cycle 50 of a run -> ignored; done still appears after 130 cycles.
REQ-040 Reset mid-run:
- Drop rst_n at cycle 40 (inside RD0) -> ram_ena=0 and busy=0 immediately.
- Release rst_n and pulse start -> full 130-cycle run with pass=1.
